// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller for the 5-stage in-order core: RAW stall on decode,
// back-end freeze while memory is busy, IF/ID flush after a redirect, and perf counters.
//
// state | meaning
// RUN   | normal issue; RAW hazards stall decode
// FLUSH | fetch is on the wrong path; IF/ID flushed while fcnt counts down
module pipe_hazard_ctl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_en_rd,
  input  logic             mem_busy,
  input  logic             ex_redirect,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             stall_mem_wb,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic       S_RUN      = 1'b0;
  localparam logic       S_FLUSH    = 1'b1;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  logic       state;
  logic [2:0] fcnt;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_en, mem_en, wb_en;

  logic freeze, rs1_hit, rs2_hit, raw, redir, wrong, raw_stall, bubble;

  assign freeze = mem_busy;

  // WB counts as a hazard: the register file has no write-through bypass.
  assign rs1_hit = id_use_rs1 && (id_rs1 != 5'd0) &&
                   ((ex_en && ex_rd == id_rs1) || (mem_en && mem_rd == id_rs1) ||
                    (wb_en && wb_rd == id_rs1));
  assign rs2_hit = id_use_rs2 && (id_rs2 != 5'd0) &&
                   ((ex_en && ex_rd == id_rs2) || (mem_en && mem_rd == id_rs2) ||
                    (wb_en && wb_rd == id_rs2));

  assign raw       = id_valid && (rs1_hit || rs2_hit);
  assign redir     = ex_redirect && !freeze;
  assign wrong     = redir || (state == S_FLUSH);
  assign raw_stall = raw && !wrong;
  assign bubble    = !freeze && (wrong || raw || !id_valid);

  // While reset is held the pipeline registers must load NOPs.
  assign stall_id_ex  = reset && freeze;
  assign stall_ex_mem = reset && freeze;
  assign stall_mem_wb = reset && freeze;
  assign stall_if_id  = reset && (freeze || raw_stall);
  assign bubble_ex    = !reset || bubble;
  assign flush_if_id  = !reset || (!freeze && wrong);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RUN;
      fcnt  <= 3'd0;
    end else if (!freeze) begin
      if (redir) begin
        if (FLUSH_CYCLES > 0) begin
          state <= S_FLUSH;
          fcnt  <= FLUSH_LOAD;
        end
      end else if (state == S_FLUSH) begin
        fcnt <= fcnt - 3'd1;
        if (fcnt == 3'd1) state <= S_RUN;
      end
    end
  end

  // A frozen MEM/WB register drops en_rd, so the WB shadow must follow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_rd  <= 5'd0;
      mem_rd <= 5'd0;
      wb_rd  <= 5'd0;
      ex_en  <= 1'b0;
      mem_en <= 1'b0;
      wb_en  <= 1'b0;
    end else if (freeze) begin
      wb_en <= 1'b0;
    end else begin
      wb_rd  <= mem_rd;
      wb_en  <= mem_en;
      mem_rd <= ex_rd;
      mem_en <= ex_en;
      ex_rd  <= id_rd;
      ex_en  <= id_en_rd && !bubble;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((freeze || raw_stall) && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
      if (redir && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl: directed scenarios plus randomized
// traffic compared against an in-flight-destination reference model.
module tb_pipe_hazard_ctl;
  localparam int FC   = 2;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_use_rs1, id_use_rs2, id_en_rd, mem_busy, ex_redirect;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, bubble_ex, flush_if_id;
  logic [CW-1:0] stall_cycles, flush_count;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_en_rd(id_en_rd),
    .mem_busy(mem_busy), .ex_redirect(ex_redirect),
    .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Reference model: list of destinations in flight (youngest first) and
  // a count of wrong-path fetch cycles still to flush.
  logic [4:0] m_rd[3];
  logic       m_en[3];
  int         m_flush_left, m_stall, m_flush;
  logic       e_freeze, e_redir, e_stall_if_id, e_bubble, e_flush;

  function automatic logic pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    for (int i = 0; i < 3; i++)
      if (m_en[i] && m_rd[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_rd[i] = 5'd0;
      m_en[i] = 1'b0;
    end
    m_flush_left = 0;
    m_stall      = 0;
    m_flush      = 0;
  endtask

  task automatic model_eval();
    logic raw, wrong;
    e_freeze      = mem_busy;
    raw           = id_valid && ((id_use_rs1 && pending(id_rs1)) || (id_use_rs2 && pending(id_rs2)));
    e_redir       = ex_redirect && !e_freeze;
    wrong         = e_redir || (m_flush_left > 0);
    e_stall_if_id = e_freeze || (raw && !wrong);
    e_flush       = !e_freeze && wrong;
    e_bubble      = !e_freeze && (wrong || raw || !id_valid);
  endtask

  task automatic model_commit();
    if (e_freeze) begin
      m_en[2] = 1'b0;
    end else begin
      for (int i = 2; i > 0; i--) begin
        m_rd[i] = m_rd[i-1];
        m_en[i] = m_en[i-1];
      end
      m_rd[0] = id_rd;
      m_en[0] = id_en_rd && !e_bubble;
      if (e_redir) m_flush_left = FC;
      else if (m_flush_left > 0) m_flush_left--;
    end
    if (e_stall_if_id && m_stall < CMAX) m_stall++;
    if (e_redir && m_flush < CMAX) m_flush++;
  endtask

  task automatic idle_in();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_en_rd = 0; mem_busy = 0; ex_redirect = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic en);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_en_rd = en;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    model_clear();
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_commit();
    #1;
  endtask

  task automatic test_reset();
    idle_in();
    reset = 0;
    set_id(1, 5'd3, 1, 5'd4, 1, 5'd3, 1);
    mem_busy = 1; ex_redirect = 1;
    @(negedge clk);
    checks++;
    if ({stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb} !== 4'b0000) begin
      errors++; $display("FAIL reset_stall: got %b exp 0000",
                         {stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb});
    end
    checks++;
    if ({bubble_ex, flush_if_id} !== 2'b11) begin
      errors++; $display("FAIL reset_bubble_flush: got %b exp 11", {bubble_ex, flush_if_id});
    end
    checks++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d exp 0/0", stall_cycles, flush_count);
    end
    do_reset();
    settle();
    checks++;
    if ({stall_if_id, flush_if_id, bubble_ex} !== 3'b001) begin
      errors++; $display("FAIL reset_idle: got %b exp 001", {stall_if_id, flush_if_id, bubble_ex});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1);
    settle();
    checks++;
    if ({stall_if_id, bubble_ex} !== 2'b00) begin
      errors++; $display("FAIL b2b_producer: got %b exp 00", {stall_if_id, bubble_ex});
    end
    tick();
    set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1);
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if ({stall_if_id, bubble_ex} !== 2'b11) begin
        errors++; $display("FAIL b2b_stall cyc%0d: got %b exp 11", c, {stall_if_id, bubble_ex});
      end
      tick();
    end
    settle();
    checks++;
    if ({stall_if_id, bubble_ex} !== 2'b00) begin
      errors++; $display("FAIL b2b_issue: got %b exp 00", {stall_if_id, bubble_ex});
    end
    tick();
    checks++;
    if (stall_cycles !== CW'(3)) begin
      errors++; $display("FAIL b2b_count: got %0d exp 3", stall_cycles);
    end
  endtask

  task automatic test_x0_unused();
    do_reset();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd0, 1);
    tick();
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd2, 0);
    settle();
    checks++;
    if ({stall_if_id, bubble_ex} !== 2'b00) begin
      errors++; $display("FAIL x0_no_stall: got %b exp 00", {stall_if_id, bubble_ex});
    end
    tick();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd7, 1);
    tick();
    set_id(1, 5'd3, 1, 5'd7, 0, 5'd8, 1);
    settle();
    checks++;
    if ({stall_if_id, bubble_ex} !== 2'b00) begin
      errors++; $display("FAIL unused_rs2: got %b exp 00", {stall_if_id, bubble_ex});
    end
    id_use_rs2 = 1;
    settle();
    checks++;
    if ({stall_if_id, bubble_ex} !== 2'b11) begin
      errors++; $display("FAIL used_rs2: got %b exp 11", {stall_if_id, bubble_ex});
    end
    tick();
  endtask

  task automatic test_freeze();
    do_reset();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1);
    tick();
    idle_in();
    repeat (2) tick();
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd6, 1);
    mem_busy = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++;
      if ({stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, bubble_ex, flush_if_id} !== 6'b111100) begin
        errors++; $display("FAIL freeze cyc%0d: got %b exp 111100", c,
                           {stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, bubble_ex, flush_if_id});
      end
      tick();
    end
    mem_busy = 0;
    settle();
    checks++;
    if ({stall_if_id, stall_id_ex, bubble_ex} !== 3'b000) begin
      errors++; $display("FAIL freeze_release: got %b exp 000", {stall_if_id, stall_id_ex, bubble_ex});
    end
    tick();
    checks++;
    if (stall_cycles !== CW'(4)) begin
      errors++; $display("FAIL freeze_count: got %0d exp 4", stall_cycles);
    end
    // Producer then freeze then dependent: remaining RAW stalls follow the freeze.
    do_reset();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd9, 1);
    tick();
    set_id(1, 5'd9, 1, 5'd0, 0, 5'd10, 1);
    mem_busy = 1;
    repeat (2) tick();
    mem_busy = 0;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if ({stall_if_id, stall_id_ex, bubble_ex} !== 3'b101) begin
        errors++; $display("FAIL freeze_then_raw cyc%0d: got %b exp 101", c,
                           {stall_if_id, stall_id_ex, bubble_ex});
      end
      tick();
    end
    settle();
    checks++;
    if (stall_if_id !== 1'b0) begin
      errors++; $display("FAIL freeze_then_issue: got %b exp 0", stall_if_id);
    end
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1);
    tick();
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd6, 1);
    ex_redirect = 1;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if ({stall_if_id, flush_if_id, bubble_ex} !== 3'b011) begin
        errors++; $display("FAIL redirect_flush cyc%0d: got %b exp 011", c,
                           {stall_if_id, flush_if_id, bubble_ex});
      end
      tick();
      ex_redirect = 0;
    end
    settle();
    checks++;
    if ({stall_if_id, flush_if_id, bubble_ex} !== 3'b000) begin
      errors++; $display("FAIL redirect_end: got %b exp 000", {stall_if_id, flush_if_id, bubble_ex});
    end
    tick();
    checks++;
    if (flush_count !== CW'(1) || stall_cycles !== '0) begin
      errors++; $display("FAIL redirect_counts: got %0d/%0d exp 1/0", flush_count, stall_cycles);
    end
  endtask

  task automatic test_redirect_freeze();
    do_reset();
    ex_redirect = 1;
    mem_busy = 1;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if ({flush_if_id, bubble_ex, stall_if_id} !== 3'b001) begin
        errors++; $display("FAIL redir_frozen cyc%0d: got %b exp 001", c,
                           {flush_if_id, bubble_ex, stall_if_id});
      end
      tick();
    end
    checks++;
    if (flush_count !== '0) begin
      errors++; $display("FAIL redir_frozen_count: got %0d exp 0", flush_count);
    end
    mem_busy = 0;
    settle();
    checks++;
    if (flush_if_id !== 1'b1) begin
      errors++; $display("FAIL redir_accept: got %b exp 1", flush_if_id);
    end
    tick();
    ex_redirect = 0;
    repeat (3) tick();
    checks++;
    if (flush_count !== CW'(1)) begin
      errors++; $display("FAIL redir_once: got %0d exp 1", flush_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ex_redirect = 1;
    tick();
    ex_redirect = 0;
    #2;
    reset = 0;
    #1;
    checks++;
    if ({stall_if_id, stall_id_ex, flush_if_id, bubble_ex, flush_count} !== {4'b0011, CW'(0)}) begin
      errors++; $display("FAIL async_mid_flush: got %b/%0d exp 0011/0",
                         {stall_if_id, stall_id_ex, flush_if_id, bubble_ex}, flush_count);
    end
    @(posedge clk); #1;
    reset = 1;
    model_clear();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd12, 1);
    tick();
    set_id(1, 5'd12, 1, 5'd0, 0, 5'd13, 1);
    tick();
    #2;
    reset = 0;
    #1;
    checks++;
    if ({stall_if_id, flush_if_id, bubble_ex, stall_cycles} !== {3'b011, CW'(0)}) begin
      errors++; $display("FAIL async_mid_stall: got %b/%0d exp 011/0",
                         {stall_if_id, flush_if_id, bubble_ex}, stall_cycles);
    end
    @(posedge clk); #1;
    reset = 1;
    model_clear();
    settle();
    checks++;
    if ({stall_if_id, flush_if_id, bubble_ex} !== 3'b000) begin
      errors++; $display("FAIL async_first_issue: got %b exp 000", {stall_if_id, flush_if_id, bubble_ex});
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    mem_busy = 1;
    repeat (CMAX + 10) tick();
    checks++;
    if (stall_cycles !== CW'(CMAX)) begin
      errors++; $display("FAIL stall_saturate: got %0d exp %0d", stall_cycles, CMAX);
    end
    mem_busy = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      set_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
      mem_busy    = $urandom_range(0, 99) < 15;
      ex_redirect = $urandom_range(0, 99) < 8;
      settle();
      checks++;
      if ({stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, bubble_ex, flush_if_id} !==
          {e_stall_if_id, e_freeze, e_freeze, e_freeze, e_bubble, e_flush}) begin
        errors++; $display("FAIL rand_ctl cyc%0d: got %b exp %b", c,
                           {stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, bubble_ex, flush_if_id},
                           {e_stall_if_id, e_freeze, e_freeze, e_freeze, e_bubble, e_flush});
      end
      checks++;
      if (stall_cycles !== CW'(m_stall) || flush_count !== CW'(m_flush)) begin
        errors++; $display("FAIL rand_counters cyc%0d: got %0d/%0d exp %0d/%0d", c,
                           stall_cycles, flush_count, m_stall, m_flush);
      end
      tick();
    end
  endtask

  initial begin
    idle_in();
    reset = 0;
    model_clear();
    test_reset();
    test_back_to_back();
    test_x0_unused();
    test_freeze();
    test_redirect();
    test_redirect_freeze();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctl.md
# pipe_hazard_ctl

Pipeline hazard controller for the 5-stage in-order core: it produces the per-stage `stall`, bubble and flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It keeps a shadow copy of the destination register in flight in EX, MEM and WB, and stalls decode on read-after-write hazards (the core has no forwarding). It freezes the back end while memory is busy and flushes wrong-path instructions after a taken branch or jump. Two performance counters report stall and flush activity.

## Interface
- `FLUSH_CYCLES`, default 1: extra cycles after a redirect during which IF/ID is flushed, covering I-fetch latency. Legal range 0-7.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  the decode stage holds a valid instruction.
- `id_rs1`, `id_rs2`  in  5 each  source register indices of the instruction in decode.
- `id_use_rs1`, `id_use_rs2`  in  1 each  the instruction reads that source.
- `id_rd`  in  5  destination register of the instruction in decode.
- `id_en_rd`  in  1  the instruction in decode writes `id_rd`.
- `mem_busy`  in  1  the MEM-stage access has not completed this cycle.
- `ex_redirect`  in  1  EX resolved a taken branch or jump this cycle.
- `stall_if_id`  out  1  hold IF/ID and the PC.
- `stall_id_ex`, `stall_ex_mem`, `stall_mem_wb`  out  1 each  hold the corresponding pipeline register.
- `bubble_ex`  out  1  ID/EX loads a NOP (`en_rd`=0) instead of the decode output.
- `flush_if_id`  out  1  IF/ID loads a NOP.
- `stall_cycles`  out  `CNT_W`  count of cycles with freeze or RAW stall.
- `flush_count`  out  `CNT_W`  count of accepted redirects.

## Operation
- Shadow state holds `ex_rd`/`ex_en`, `mem_rd`/`mem_en` and `wb_rd`/`wb_en`. It mirrors the pipeline registers.
- `freeze` = `mem_busy`.
- `match(r)` = (`ex_en` & `ex_rd`==r) | (`mem_en` & `mem_rd`==r) | (`wb_en` & `wb_rd`==r).
- `raw` = `id_valid` & ((`id_use_rs1` & `id_rs1`≠0 & `match(id_rs1)`) | (`id_use_rs2` & `id_rs2`≠0 & `match(id_rs2)`)).
  - x0 never causes a hazard.
  - A WB match is a hazard: the register file writes at the clock edge and has no internal bypass.
- `redir` = `ex_redirect` & !`freeze`. A redirect arriving during a freeze is ignored; EX holds and re-presents it.
- FSM has two states, RUN and FLUSH, with a 3-bit down-counter `fcnt`.
  - RUN → FLUSH on `redir` when `FLUSH_CYCLES`>0; `fcnt` ← `FLUSH_CYCLES`.
  - In FLUSH, when !`freeze`: `fcnt` decrements. FLUSH → RUN when `fcnt` reaches 0 after the decrement.
  - `redir` while in FLUSH reloads `fcnt` ← `FLUSH_CYCLES`.
  - A freeze holds the FSM and `fcnt` unchanged.
- `wrong` = `redir` | (state==FLUSH).
- Output equations (combinational from state and inputs):
  - `stall_ex_mem` = `stall_mem_wb` = `stall_id_ex` = `freeze`.
  - `stall_if_id` = `freeze` | (`raw` & !`wrong`).
  - `flush_if_id` = !`freeze` & `wrong`.
  - `bubble_ex` = !`freeze` & (`wrong` | `raw` | !`id_valid`).
- Shadow update at each edge:
  - freeze: `ex`/`mem`/`wb` hold, except `wb_en` ← 0. This matches the MEM/WB register dropping `en_rd` during a stall.
  - otherwise: `wb` ← `mem`, `mem` ← `ex`. `ex` ← (`id_rd`, `id_en_rd`) if !`bubble_ex`, else (x, 0).
- Counters (both saturating at all-ones):
  - `stall_cycles` increments when `freeze` | (`raw` & !`wrong`).
  - `flush_count` increments on `redir`.

## Timing
- Reset (`reset`=0, asynchronous) clears all shadow `en` bits, sets state RUN and `fcnt` 0, and clears both counters.
- While `reset`=0, outputs are forced: all `stall_*`=0, `bubble_ex`=1, `flush_if_id`=1.
- Reset deassertion is synchronous to `clk`. The first active edge after deassertion behaves as RUN with an empty shadow.
- Hazard detection has zero-cycle latency: outputs reflect the same-cycle inputs and are sampled by the pipeline registers at the next edge.
- A producer followed immediately by a dependent instruction stalls for 3 cycles (producer in EX, MEM, WB). Distance 2 stalls 2 cycles; distance 3 stalls 1; distance 4 or more, 0.
- Precedence: freeze > redirect/FLUSH > RAW.
- Reset mid-FLUSH or mid-freeze aborts immediately to the reset state.

## Test plan
- Back-to-back RAW: `addi x5` then `add x6,x5,x1`, `mem_busy`=0 → `stall_if_id`=1 and `bubble_ex`=1 for exactly 3 cycles, then the consumer issues; `stall_cycles`=3.
- x0 and unused sources: producer writes x0, or consumer has `id_use_rs2`=0 on a matching register → no stall.
- Freeze: `mem_busy` high for 4 cycles with a producer in WB → all `stall_*`=1 for 4 cycles, `wb_en` cleared after the first cycle; `stall_cycles`=4; the dependent instruction's stall resumes correctly afterwards.
- Redirect with `FLUSH_CYCLES`=2 → `flush_if_id`=1 and `bubble_ex`=1 for 3 cycles, RAW ignored during them; `flush_count`=1.
- Redirect with `mem_busy`=1 → ignored until `mem_busy` falls, then accepted once; `flush_count` increments by 1 only.
- Async reset asserted mid-FLUSH and mid-stall → outputs forced immediately, counters 0; after release the first instruction issues with no stall.
